my_dmaster: RTL

MY_DMASTER -- requirements
Module: my_dmaster

---
 rtl/my_dmaster_if.sv | 26 ++
 rtl/my_dmaster.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/my_dmaster_if.sv
// Avalon-MM style write-only bus between my_dmaster and its slave.
interface my_dmaster_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();

  logic [AW-1:0] avm_m0_address;
  logic [DW-1:0] avm_m0_writedata;
  logic          avm_m0_write;
  logic          avm_m0_waitrequest;

  modport master (
    output avm_m0_address,
    output avm_m0_writedata,
    output avm_m0_write,
    input  avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_writedata,
    input  avm_m0_write,
    output avm_m0_waitrequest
  );

endinterface

// File: rtl/my_dmaster.sv
// my_dmaster: issues a burst of single writes of incrementing data to one
// fixed address, optionally spacing them with idle cycles.
// All outputs come straight from registers.
module my_dmaster #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int TGT_ADDR = 0,
  parameter int GAP      = 0
) (
  input  logic          csi_clk,
  input  logic          rsi_reset,
  my_dmaster_if.master  avm_m0,
  input  logic          coe_m0_start,
  input  logic [7:0]    coe_m0_len,
  input  logic [DW-1:0] coe_m0_data,
  output logic          coe_m0_busy,
  output logic          coe_m0_done,
  output logic [7:0]    coe_m0_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] TGT      = AW'(TGT_ADDR);
  localparam logic          HAS_GAP  = (GAP > 0) ? 1'b1 : 1'b0;
  // Last value of the gap counter; only meaningful when GAP > 0.
  localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  logic [1:0]    r_state,     w_state;
  logic [7:0]    r_len,       w_len;
  logic [DW-1:0] r_data,      w_data;
  logic [7:0]    r_count,     w_count;
  logic [7:0]    r_gap_cnt,   w_gap_cnt;
  logic          r_write,     w_write;
  logic [AW-1:0] r_address,   w_address;
  logic [DW-1:0] r_writedata, w_writedata;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;

  logic [7:0]    w_count_inc;
  logic [DW-1:0] w_data_inc;

  assign w_count_inc = r_count + 8'd1;
  assign w_data_inc  = r_data + DW'(1);

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_data      = r_data;
    w_count     = r_count;
    w_gap_cnt   = r_gap_cnt;
    w_write     = r_write;
    w_address   = r_address;
    w_writedata = r_writedata;
    w_busy      = r_busy;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (coe_m0_start) begin
          w_count = 8'd0;
          if (coe_m0_len != 8'd0) begin
            w_state     = S_WRITE;
            w_len       = coe_m0_len;
            w_data      = coe_m0_data;
            w_write     = 1'b1;
            w_address   = TGT;
            w_writedata = coe_m0_data;
            w_busy      = 1'b1;
          end else begin
            // Empty command: complete immediately without touching the bus.
            w_state     = S_DONE;
            w_write     = 1'b0;
            w_address   = '0;
            w_writedata = '0;
            w_busy      = 1'b0;
            w_done      = 1'b1;
          end
        end else begin
          w_write     = 1'b0;
          w_address   = '0;
          w_writedata = '0;
          w_busy      = 1'b0;
        end
      end

      S_WRITE: begin
        if (!avm_m0.avm_m0_waitrequest) begin
          w_count = w_count_inc;
          w_data  = w_data_inc;
          if (w_count_inc == r_len) begin
            w_state     = S_DONE;
            w_write     = 1'b0;
            w_address   = '0;
            w_writedata = '0;
            w_busy      = 1'b0;
            w_done      = 1'b1;
          end else if (HAS_GAP) begin
            w_state     = S_GAP;
            w_gap_cnt   = 8'd0;
            w_write     = 1'b0;
            w_address   = '0;
            w_writedata = '0;
          end else begin
            // Back-to-back: present the next word on the very next cycle.
            w_writedata = w_data_inc;
          end
        end else begin
          // Stalled: everything on the bus holds.
          w_write     = 1'b1;
          w_address   = TGT;
          w_writedata = r_writedata;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state     = S_WRITE;
          w_write     = 1'b1;
          w_address   = TGT;
          w_writedata = r_data;
        end else begin
          w_gap_cnt = r_gap_cnt + 8'd1;
        end
      end

      S_DONE: begin
        // Any start seen here is deliberately dropped.
        w_state     = S_IDLE;
        w_write     = 1'b0;
        w_address   = '0;
        w_writedata = '0;
        w_busy      = 1'b0;
      end

      default: begin
        w_state     = S_IDLE;
        w_write     = 1'b0;
        w_address   = '0;
        w_writedata = '0;
        w_busy      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any write.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      r_state     <= S_IDLE;
      r_len       <= 8'd0;
      r_data      <= '0;
      r_count     <= 8'd0;
      r_gap_cnt   <= 8'd0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_len       <= w_len;
      r_data      <= w_data;
      r_count     <= w_count;
      r_gap_cnt   <= w_gap_cnt;
      r_write     <= w_write;
      r_address   <= w_address;
      r_writedata <= w_writedata;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign avm_m0.avm_m0_write     = r_write;
  assign avm_m0.avm_m0_address   = r_address;
  assign avm_m0.avm_m0_writedata = r_writedata;
  assign coe_m0_busy             = r_busy;
  assign coe_m0_done             = r_done;
  assign coe_m0_count            = r_count;

endmodule
